dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
- Bus master that drives a linear frequency sweep on one DDS channel.
- Sits between a local control register file and the DDS slave write channel.
- Issues single-beat writes to a channel's freq_ctrl register: start frequency, then a fixed step repeated N times, with a programmable dwell between writes.
- Optional single or looped pass; sticky error reporting on bad bus responses.

Parameters:
- OFFSER_ADDR, 32'h4000_0000, base address of the DDS slave, added to every register offset.
- CHANNEL_NUM, 2, number of DDS channels; channel indices at or above this value are rejected.
- DWELL_W, 24, width of the dwell counter.
- STEP_W, 16, width of the step counter.

Ports:
- clk  in  1  single clock, shared with the DDS slave.
- rstn  in  1  asynchronous, active-low reset.
- sweep_start  in  1  one-cycle pulse; sampled only in IDLE.
- sweep_stop  in  1  one-cycle pulse; graceful abort.
- cfg_channel  in  4  target channel.
- cfg_store  in  2  target waveform store 0..3.
- cfg_freq_start  in  32  first freq_ctrl value.
- cfg_freq_step  in  32  increment added per step; two's complement, so downward sweeps are allowed.
- cfg_step_count  in  STEP_W  number of increments; total writes = cfg_step_count+1.
- cfg_dwell  in  DWELL_W  clock cycles between write completion and next address phase.
- cfg_loop  in  1  restart from cfg_freq_start after the final write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on every return to IDLE.
- err  out  1  sticky error flag; cleared by an accepted start.
- cur_freq  out  32  value most recently written, or about to be written.
- M_WR_ADDR_ID  out  4  constant 4'h0.
- M_WR_ADDR  out  32  target register address.
- M_WR_ADDR_LEN  out  8  constant 0.
- M_WR_ADDR_BURST  out  2  constant 2'b01.
- M_WR_ADDR_VALID  out  1  address valid.
- M_WR_ADDR_READY  in  1  address ready.
- M_WR_DATA  out  32  equals cur_freq.
- M_WR_STRB  out  4  constant 4'hF.
- M_WR_DATA_LAST  out  1  high whenever M_WR_DATA_VALID is high.
- M_WR_DATA_VALID  out  1  data valid.
- M_WR_DATA_READY  in  1  data ready.
- M_WR_BACK_ID  in  4  ignored.
- M_WR_BACK_RESP  in  2  2'b00 = OK; any other value is an error.
- M_WR_BACK_VALID  in  1  response valid.
- M_WR_BACK_READY  out  1  response ready.

Behaviour:
- Reset values: all outputs 0 except the constant bus fields; state IDLE; all counters 0.
- Address: M_WR_ADDR = OFFSER_ADDR + {cfg_channel,4'h0} + 1 + cfg_store. The address, step, dwell and loop settings are latched at start.
- States: IDLE, ADDR, DATA, RESP, DWELL.
- IDLE:
  - start with cfg_channel < CHANNEL_NUM: latch config, cur_freq <= cfg_freq_start, idx <= 0, clear err, go to ADDR.
  - start with cfg_channel >= CHANNEL_NUM: err <= 1, done pulse, stay in IDLE.
  - start and stop in the same cycle: stop wins; nothing happens.
- ADDR: ADDR_VALID high until ADDR_READY is seen; then go to DATA. VALID never drops before the handshake.
- DATA: DATA_VALID and LAST high until DATA_READY is seen; then go to RESP.
- RESP: BACK_READY high.
  - On the handshake, a non-zero RESP sets err and returns to IDLE.
  - Otherwise, if stop_pending, return to IDLE.
  - Otherwise, if idx == step_count:
    - cfg_loop = 1: cur_freq <= freq_start, idx <= 0, go to DWELL.
    - cfg_loop = 0: return to IDLE.
  - Otherwise: cur_freq <= cur_freq + freq_step (mod 2^32, wrap allowed), idx <= idx+1, go to DWELL.
- DWELL:
  - Counter loads max(dwell,1) and counts down.
  - At 1, go to ADDR.
  - A stop in DWELL returns to IDLE on the next cycle.
- Stop in ADDR, DATA or RESP sets stop_pending. The current transaction completes, then the block returns to IDLE. stop_pending is cleared in IDLE.
- Latency: start to ADDR_VALID is 1 cycle. With zero-wait bus, write-to-write spacing is 3 + max(dwell,1) cycles.
- Reset asserted mid-transaction drops all VALID/READY outputs immediately; no resumption after reset.

Optional Feature:
- Macro: DDS_SWEEP_WAVESEL_EN.
- Defined: at the start of each pass, a single-beat write of cfg_store to offset {cfg_channel,4'h0} precedes the first freq write. The DDS output then switches to the swept store. This uses an extra state WSEL_ADDR/WSEL_DATA/WSEL_RESP, and an error response there aborts the pass.
- Undefined: wave_sel is never written.

Decomposition:
- Package dds_pkg: state enum, RESP_OKAY = 2'b00, BURST_INCR = 2'b01, REG_WAVE_SEL = 4'h0, REG_FREQ_BASE = 4'h1.
- Sub-module dds_dwell_timer: load/count-down/expire pulse.
- FSM and address/step logic stay in the top level.

Test Plan:
- Basic sweep: start with ch=1, store=2, freq_start=0x100, step=0x10, count=3, dwell=4, zero-wait slave.
  - Required: 4 writes to 0x4000_0013 with data 0x100, 0x110, 0x120, 0x130.
  - Required: spacing 7 cycles; done pulse; busy low.
- Wrap: freq_start=0xFFFF_FFF0, step=0x20, count=1 -> data 0xFFFF_FFF0 then 0x0000_0010.
- Backpressure: ADDR_READY delayed 5 cycles and DATA_READY delayed 3 cycles.
  - Required: VALIDs stay high and data stays stable; same write sequence as the basic sweep.
- Error: slave returns RESP=2'b10 on the 2nd write -> err=1, IDLE, no 3rd write; the next start clears err.
- Stop: stop during RESP of write 2 -> write 2 completes, no further writes. cfg_loop=1 with stop in DWELL -> IDLE on the next cycle.
- Bad channel: ch=2 with CHANNEL_NUM=2 -> no bus activity, err=1, done pulse.

Source files
------------

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and register map for the DDS linear-sweep bus master.
package dds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DWELL,
    ST_WSEL_ADDR,
    ST_WSEL_DATA,
    ST_WSEL_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] REG_WAVE_SEL  = 4'h0;
  localparam logic [3:0] REG_FREQ_BASE = 4'h1;

  // Each channel owns a 16-byte register window starting at base + ch*16.
  function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                           input logic [3:0]  ch,
                                           input logic [3:0]  off);
    return base + {24'h0, ch, off};
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_dwell.sv
// Dwell timer: loads max(value,1), counts down, o_expire high while the count is 1.
// Latency: expire asserts value-1 cycles after the load cycle; no backpressure.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [DWELL_W-1:0] i_value,
  output logic               o_expire
);

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_value == '0) ? ONE : i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_expire = (r_cnt == ONE);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep master: start value then N signed steps to one DDS freq_ctrl register.
// Optional wave_sel write at the start of every pass under `DDS_SWEEP_WAVESEL_EN.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter logic [31:0] OFFSER_ADDR = 32'h4000_0000,
  parameter int          CHANNEL_NUM = 2,
  parameter int          DWELL_W     = 24,
  parameter int          STEP_W      = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sweep_start,
  input  logic               sweep_stop,
  input  logic [3:0]         cfg_channel,
  input  logic [1:0]         cfg_store,
  input  logic [31:0]        cfg_freq_start,
  input  logic [31:0]        cfg_freq_step,
  input  logic [STEP_W-1:0]  cfg_step_count,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        cur_freq,
  output logic [3:0]         M_WR_ADDR_ID,
  output logic [31:0]        M_WR_ADDR,
  output logic [7:0]         M_WR_ADDR_LEN,
  output logic [1:0]         M_WR_ADDR_BURST,
  output logic               M_WR_ADDR_VALID,
  input  logic               M_WR_ADDR_READY,
  output logic [31:0]        M_WR_DATA,
  output logic [3:0]         M_WR_STRB,
  output logic               M_WR_DATA_LAST,
  output logic               M_WR_DATA_VALID,
  input  logic               M_WR_DATA_READY,
  input  logic [3:0]         M_WR_BACK_ID,
  input  logic [1:0]         M_WR_BACK_RESP,
  input  logic               M_WR_BACK_VALID,
  output logic               M_WR_BACK_READY
);

  localparam logic [4:0]        CH_LIMIT = 5'(CHANNEL_NUM);
  localparam logic [STEP_W-1:0] IDX_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

`ifdef DDS_SWEEP_WAVESEL_EN
  localparam state_t FIRST_ST = ST_WSEL_ADDR;
`else
  localparam state_t FIRST_ST = ST_ADDR;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_freq_start;
  logic [31:0]        r_freq_step;
  logic [STEP_W-1:0]  r_step_count;
  logic [STEP_W-1:0]  r_idx;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop;
  logic [31:0]        r_cur_freq;
  logic               r_err;
  logic               r_done;
  logic               r_stop_pending;

  logic w_ch_ok;
  logic w_resp_bad;
  logic w_stop_req;
  logic w_accept;
  logic w_set_err;
  logic w_done;
  logic w_advance;
  logic w_restart;
  logic w_dwell_load;
  logic w_dwell_clr;
  logic w_dwell_expire;
  logic w_unused_id;

`ifdef DDS_SWEEP_WAVESEL_EN
  logic [31:0] r_wsel_addr;
  logic [1:0]  r_store;
  logic        r_wsel_pend;
  logic        w_in_wsel;
`endif

  assign w_ch_ok     = ({1'b0, cfg_channel} < CH_LIMIT);
  assign w_resp_bad  = (M_WR_BACK_RESP != RESP_OKAY);
  assign w_stop_req  = r_stop_pending | sweep_stop;
  assign w_unused_id = ^M_WR_BACK_ID;

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (w_dwell_load),
    .i_clear  (w_dwell_clr),
    .i_value  (r_dwell),
    .o_expire (w_dwell_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_set_err    = 1'b0;
    w_done       = 1'b0;
    w_advance    = 1'b0;
    w_restart    = 1'b0;
    w_dwell_load = 1'b0;
    w_dwell_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A simultaneous stop cancels the start outright, including the channel check.
        if (sweep_start && !sweep_stop) begin
          if (w_ch_ok) begin
            w_accept = 1'b1;
            w_next   = FIRST_ST;
          end else begin
            w_set_err = 1'b1;
            w_done    = 1'b1;
          end
        end
      end
      ST_ADDR: if (M_WR_ADDR_READY) w_next = ST_DATA;
      ST_DATA: if (M_WR_DATA_READY) w_next = ST_RESP;
      ST_RESP: begin
        if (M_WR_BACK_VALID) begin
          if (w_resp_bad) begin
            w_set_err = 1'b1;
            w_done    = 1'b1;
            w_next    = ST_IDLE;
          end else if (w_stop_req) begin
            w_done = 1'b1;
            w_next = ST_IDLE;
          end else if (r_idx == r_step_count) begin
            if (r_loop) begin
              w_restart    = 1'b1;
              w_dwell_load = 1'b1;
              w_next       = ST_DWELL;
            end else begin
              w_done = 1'b1;
              w_next = ST_IDLE;
            end
          end else begin
            w_advance    = 1'b1;
            w_dwell_load = 1'b1;
            w_next       = ST_DWELL;
          end
        end
      end
      ST_DWELL: begin
        if (sweep_stop) begin
          w_dwell_clr = 1'b1;
          w_done      = 1'b1;
          w_next      = ST_IDLE;
        end else if (w_dwell_expire) begin
`ifdef DDS_SWEEP_WAVESEL_EN
          w_next = r_wsel_pend ? ST_WSEL_ADDR : ST_ADDR;
`else
          w_next = ST_ADDR;
`endif
        end
      end
`ifdef DDS_SWEEP_WAVESEL_EN
      ST_WSEL_ADDR: if (M_WR_ADDR_READY) w_next = ST_WSEL_DATA;
      ST_WSEL_DATA: if (M_WR_DATA_READY) w_next = ST_WSEL_RESP;
      ST_WSEL_RESP: begin
        if (M_WR_BACK_VALID) begin
          if (w_resp_bad) begin
            w_set_err = 1'b1;
            w_done    = 1'b1;
            w_next    = ST_IDLE;
          end else if (w_stop_req) begin
            w_done = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_next = ST_ADDR;
          end
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr       <= '0;
      r_freq_start <= '0;
      r_freq_step  <= '0;
      r_step_count <= '0;
      r_idx        <= '0;
      r_dwell      <= '0;
      r_loop       <= 1'b0;
      r_cur_freq   <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_accept) begin
        r_addr       <= reg_addr(OFFSER_ADDR, cfg_channel, REG_FREQ_BASE + {2'b00, cfg_store});
        r_freq_start <= cfg_freq_start;
        r_freq_step  <= cfg_freq_step;
        r_step_count <= cfg_step_count;
        r_dwell      <= cfg_dwell;
        r_loop       <= cfg_loop;
        r_cur_freq   <= cfg_freq_start;
        r_idx        <= '0;
        r_err        <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_advance) begin
        r_cur_freq <= r_cur_freq + r_freq_step;
        r_idx      <= r_idx + IDX_ONE;
      end else if (w_restart) begin
        r_cur_freq <= r_freq_start;
        r_idx      <= '0;
      end
    end
  end

  // Stops arriving mid-transaction are deferred until the response completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stop_pending <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_stop_pending <= 1'b0;
    end else if (sweep_stop && (r_state != ST_DWELL)) begin
      r_stop_pending <= 1'b1;
    end
  end

`ifdef DDS_SWEEP_WAVESEL_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wsel_addr <= '0;
      r_store     <= '0;
      r_wsel_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wsel_addr <= reg_addr(OFFSER_ADDR, cfg_channel, REG_WAVE_SEL);
        r_store     <= cfg_store;
        r_wsel_pend <= 1'b0;
      end else if (w_restart) begin
        r_wsel_pend <= 1'b1;
      end else if (r_state == ST_WSEL_ADDR) begin
        r_wsel_pend <= 1'b0;
      end
    end
  end

  assign w_in_wsel       = (r_state == ST_WSEL_ADDR) || (r_state == ST_WSEL_DATA) ||
                           (r_state == ST_WSEL_RESP);
  assign M_WR_ADDR       = w_in_wsel ? r_wsel_addr : r_addr;
  assign M_WR_DATA       = w_in_wsel ? {30'h0, r_store} : r_cur_freq;
  assign M_WR_ADDR_VALID = (r_state == ST_ADDR) || (r_state == ST_WSEL_ADDR);
  assign M_WR_DATA_VALID = (r_state == ST_DATA) || (r_state == ST_WSEL_DATA);
  assign M_WR_BACK_READY = (r_state == ST_RESP) || (r_state == ST_WSEL_RESP);
`else
  assign M_WR_ADDR       = r_addr;
  assign M_WR_DATA       = r_cur_freq;
  assign M_WR_ADDR_VALID = (r_state == ST_ADDR);
  assign M_WR_DATA_VALID = (r_state == ST_DATA);
  assign M_WR_BACK_READY = (r_state == ST_RESP);
`endif

  assign M_WR_DATA_LAST  = M_WR_DATA_VALID;
  assign M_WR_ADDR_ID    = 4'h0;
  assign M_WR_ADDR_LEN   = 8'h00;
  assign M_WR_ADDR_BURST = BURST_INCR;
  assign M_WR_STRB       = 4'hF;

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign cur_freq = r_cur_freq;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: vector table, hand-written stop/loop/reset sequences, random sweeps vs. model.
module tb_dds_sweep_ctrl;

  localparam int DWELL_W = 24;
  localparam int STEP_W  = 16;

  typedef struct {
    logic [3:0]  ch;
    logic [1:0]  st;
    logic [31:0] fstart;
    logic [31:0] fstep;
    int          cnt;
    int          dwell;
    int          aw;
    int          w;
    int          err_at;
    int          exp_nwr;
    logic [31:0] exp_addr;
    logic [31:0] exp_last;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic               sweep_start = 1'b0, sweep_stop = 1'b0;
  logic [3:0]         cfg_channel = '0;
  logic [1:0]         cfg_store = '0;
  logic [31:0]        cfg_freq_start = '0, cfg_freq_step = '0;
  logic [STEP_W-1:0]  cfg_step_count = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               cfg_loop = 1'b0;
  logic               busy, done, err;
  logic [31:0]        cur_freq;
  logic [3:0]         M_WR_ADDR_ID;
  logic [31:0]        M_WR_ADDR, M_WR_DATA;
  logic [7:0]         M_WR_ADDR_LEN;
  logic [1:0]         M_WR_ADDR_BURST;
  logic               M_WR_ADDR_VALID, M_WR_DATA_VALID, M_WR_DATA_LAST, M_WR_BACK_READY;
  logic [3:0]         M_WR_STRB;
  logic               M_WR_ADDR_READY = 1'b0, M_WR_DATA_READY = 1'b0, M_WR_BACK_VALID = 1'b0;
  logic [1:0]         M_WR_BACK_RESP = 2'b00;
  logic [3:0]         M_WR_BACK_ID = 4'h5;

  dds_sweep_ctrl dut (
    .clk(clk), .rstn(rstn), .sweep_start(sweep_start), .sweep_stop(sweep_stop),
    .cfg_channel(cfg_channel), .cfg_store(cfg_store), .cfg_freq_start(cfg_freq_start),
    .cfg_freq_step(cfg_freq_step), .cfg_step_count(cfg_step_count), .cfg_dwell(cfg_dwell),
    .cfg_loop(cfg_loop), .busy(busy), .done(done), .err(err), .cur_freq(cur_freq),
    .M_WR_ADDR_ID(M_WR_ADDR_ID), .M_WR_ADDR(M_WR_ADDR), .M_WR_ADDR_LEN(M_WR_ADDR_LEN),
    .M_WR_ADDR_BURST(M_WR_ADDR_BURST), .M_WR_ADDR_VALID(M_WR_ADDR_VALID),
    .M_WR_ADDR_READY(M_WR_ADDR_READY), .M_WR_DATA(M_WR_DATA), .M_WR_STRB(M_WR_STRB),
    .M_WR_DATA_LAST(M_WR_DATA_LAST), .M_WR_DATA_VALID(M_WR_DATA_VALID),
    .M_WR_DATA_READY(M_WR_DATA_READY), .M_WR_BACK_ID(M_WR_BACK_ID),
    .M_WR_BACK_RESP(M_WR_BACK_RESP), .M_WR_BACK_VALID(M_WR_BACK_VALID),
    .M_WR_BACK_READY(M_WR_BACK_READY)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave: decides READY at the falling edge, so a handshake seen here completes at the next rise.
  int aw_delay = 0, w_delay = 0, err_at = 0;
  int aw_wait = 0, w_wait = 0, wr_num = 0, cur_cyc = 0;
  bit w_pend = 0, b_hs_pend = 0;
  logic [31:0] cur_addr = '0, aw_hold = '0, w_hold = '0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  always @(negedge clk) begin
    if (!rstn) begin
      M_WR_ADDR_READY = 1'b0; M_WR_DATA_READY = 1'b0;
      M_WR_BACK_VALID = 1'b0; M_WR_BACK_RESP = 2'b00;
      aw_wait = 0; w_wait = 0; w_pend = 0; b_hs_pend = 0;
    end else begin
      if (b_hs_pend) begin
        M_WR_BACK_VALID = 1'b0; M_WR_BACK_RESP = 2'b00; b_hs_pend = 0;
      end
      if (w_pend) begin
        M_WR_BACK_VALID = 1'b1;
        M_WR_BACK_RESP  = (wr_num == err_at) ? 2'b10 : 2'b00;
        w_pend = 0;
      end
      if (M_WR_BACK_VALID && M_WR_BACK_READY) b_hs_pend = 1;
      M_WR_ADDR_READY = 1'b0;
      if (M_WR_ADDR_VALID) begin
        if (aw_wait == 0) aw_hold = M_WR_ADDR;
        else check("addr stable under backpressure", M_WR_ADDR, aw_hold);
        if (aw_wait >= aw_delay) begin
          M_WR_ADDR_READY = 1'b1; cur_addr = M_WR_ADDR; cur_cyc = cyc; aw_wait = 0;
        end else aw_wait++;
      end
      M_WR_DATA_READY = 1'b0;
      if (M_WR_DATA_VALID) begin
        check("last with data valid", 32'(M_WR_DATA_LAST), 32'd1);
        if (w_wait == 0) w_hold = M_WR_DATA;
        else check("data stable under backpressure", M_WR_DATA, w_hold);
        if (w_wait >= w_delay) begin
          M_WR_DATA_READY = 1'b1; w_wait = 0; wr_num++; w_pend = 1;
          q_addr.push_back(cur_addr); q_data.push_back(M_WR_DATA); q_cyc.push_back(cur_cyc);
        end else w_wait++;
      end
    end
  end

  function automatic int model_nwr(input logic [3:0] ch, input int cnt, input int e_at);
    if (ch >= 4'd2) return 0;
    if (e_at >= 1 && e_at <= cnt + 1) return e_at;
    return cnt + 1;
  endfunction

  function automatic logic model_err(input logic [3:0] ch, input int cnt, input int e_at);
    return (ch >= 4'd2) || (e_at >= 1 && e_at <= cnt + 1);
  endfunction

  function automatic logic [31:0] model_addr(input logic [3:0] ch, input logic [1:0] st);
    return 32'h4000_0000 + 32'(ch) * 32'd16 + 32'd1 + 32'(st);
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] s, input logic [31:0] d, input int k);
    return s + d * 32'(k);
  endfunction

  task automatic clear_log();
    q_addr.delete(); q_data.delete(); q_cyc.delete(); wr_num = 0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    check({tag, " done pulse"}, 32'(ok), 32'd1);
  endtask

  task automatic sweep(input vec_t v, input string tag, input bit use_tbl);
    int t0, nwr, extra, dw;
    cfg_channel = v.ch; cfg_store = v.st; cfg_freq_start = v.fstart; cfg_freq_step = v.fstep;
    cfg_step_count = v.cnt[STEP_W-1:0]; cfg_dwell = v.dwell[DWELL_W-1:0]; cfg_loop = 1'b0;
    aw_delay = v.aw; w_delay = v.w; err_at = v.err_at;
    clear_log();
    @(negedge clk);
    sweep_start = 1'b1; t0 = cyc;
    @(negedge clk);
    sweep_start = 1'b0;
    wait_done(tag);
    check({tag, " busy low at end"}, 32'(busy), 32'd0);
    extra = 0;
    repeat (4) begin @(negedge clk); if (done) extra++; end
    check({tag, " single done"}, 32'(extra), 32'd0);
    nwr = model_nwr(v.ch, v.cnt, v.err_at);
    check({tag, " write count"}, 32'(q_data.size()), 32'(nwr));
    check({tag, " err flag"}, 32'(err), 32'(model_err(v.ch, v.cnt, v.err_at)));
    for (int k = 0; k < nwr && k < q_data.size(); k++) begin
      check($sformatf("%s addr[%0d]", tag, k), q_addr[k], model_addr(v.ch, v.st));
      check($sformatf("%s data[%0d]", tag, k), q_data[k], model_data(v.fstart, v.fstep, k));
    end
    if (v.aw == 0 && v.w == 0 && q_cyc.size() > 0) begin
      dw = (v.dwell == 0) ? 1 : v.dwell;
      check({tag, " start latency"}, 32'(q_cyc[0] - t0), 32'd1);
      for (int k = 1; k < q_cyc.size(); k++)
        check($sformatf("%s spacing[%0d]", tag, k), 32'(q_cyc[k] - q_cyc[k-1]), 32'(3 + dw));
    end
    if (use_tbl) begin
      check({tag, " tbl nwr"}, 32'(q_data.size()), 32'(v.exp_nwr));
      check({tag, " tbl err"}, 32'(err), 32'(v.exp_err));
      if (v.exp_nwr > 0 && q_data.size() > 0) begin
        check({tag, " tbl addr"}, q_addr[0], v.exp_addr);
        check({tag, " tbl last data"}, q_data[q_data.size()-1], v.exp_last);
      end
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   nresp;
  bit   hit;

  initial begin
    tbl[0] = '{4'd1, 2'd2, 32'h100, 32'h10, 3, 4, 0, 0, 0, 4, 32'h4000_0013, 32'h130, 1'b0};
    tbl[1] = '{4'd0, 2'd0, 32'hFFFF_FFF0, 32'h20, 1, 0, 0, 0, 0, 2, 32'h4000_0001, 32'h10, 1'b0};
    tbl[2] = '{4'd1, 2'd2, 32'h100, 32'h10, 3, 4, 5, 3, 0, 4, 32'h4000_0013, 32'h130, 1'b0};
    tbl[3] = '{4'd1, 2'd0, 32'h1000, 32'h100, 4, 2, 0, 0, 2, 2, 32'h4000_0011, 32'h1100, 1'b1};
    tbl[4] = '{4'd2, 2'd1, 32'h1, 32'h1, 2, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1};
    tbl[5] = '{4'd0, 2'd3, 32'h500, 32'hFFFF_FF00, 2, 1, 0, 0, 0, 3, 32'h4000_0004, 32'h300, 1'b0};

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset cur_freq", cur_freq, 32'd0);
    check("reset addr valid", 32'(M_WR_ADDR_VALID), 32'd0);
    check("reset data valid", 32'(M_WR_DATA_VALID), 32'd0);
    check("reset back ready", 32'(M_WR_BACK_READY), 32'd0);
    check("reset addr", M_WR_ADDR, 32'd0);
    check("const burst", 32'(M_WR_ADDR_BURST), 32'd1);
    check("const strb", 32'(M_WR_STRB), 32'hF);
    check("const len/id", {M_WR_ADDR_LEN, 20'h0, M_WR_ADDR_ID}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) sweep(tbl[i], $sformatf("tbl%0d", i), 1'b1);

    // Stop during the response of write 2: that write completes, nothing after it.
    cfg_channel = 4'd1; cfg_store = 2'd1; cfg_freq_start = 32'h7000; cfg_freq_step = 32'h11;
    cfg_step_count = 16'd5; cfg_dwell = 24'd2; cfg_loop = 1'b0;
    aw_delay = 0; w_delay = 0; err_at = 0; clear_log(); nresp = 0; hit = 0;
    @(negedge clk); sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (M_WR_BACK_READY) nresp++;
      if (nresp == 2) begin
        sweep_stop = 1'b1; @(negedge clk); sweep_stop = 1'b0; hit = 1;
      end else @(negedge clk);
    end
    check("stop-resp reached write 2", 32'(hit), 32'd1);
    wait_done("stop-resp");
    repeat (10) @(negedge clk);
    check("stop-resp writes", 32'(q_data.size()), 32'd2);
    check("stop-resp cur_freq", cur_freq, 32'h7011);
    check("stop-resp busy", 32'(busy), 32'd0);

    // Looping pass, then a stop while dwelling: idle on the very next cycle.
    cfg_channel = 4'd0; cfg_store = 2'd0; cfg_freq_start = 32'h2000; cfg_freq_step = 32'h40;
    cfg_step_count = 16'd1; cfg_dwell = 24'd10; cfg_loop = 1'b1;
    clear_log(); nresp = 0;
    @(negedge clk); sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    for (int i = 0; i < 400 && nresp < 3; i++) begin
      if (M_WR_BACK_READY) nresp++;
      @(negedge clk);
    end
    check("loop third response", 32'(nresp), 32'd3);
    @(negedge clk);
    sweep_stop = 1'b1;
    @(negedge clk);
    sweep_stop = 1'b0;
    check("dwell-stop busy next cycle", 32'(busy), 32'd0);
    check("dwell-stop done", 32'(done), 32'd1);
    check("loop writes", 32'(q_data.size()), 32'd3);
    if (q_data.size() == 3) begin
      check("loop data0", q_data[0], 32'h2000);
      check("loop data1", q_data[1], 32'h2040);
      check("loop restart data", q_data[2], 32'h2000);
      check("loop restart spacing", 32'(q_cyc[2] - q_cyc[1]), 32'd13);
    end
    check("loop cur_freq", cur_freq, 32'h2040);
    cfg_loop = 1'b0;

    // Start and stop together with a bad channel: stop wins, so no error either.
    cfg_channel = 4'd5; clear_log();
    @(negedge clk); sweep_start = 1'b1; sweep_stop = 1'b1;
    @(negedge clk); sweep_start = 1'b0; sweep_stop = 1'b0;
    check("start+stop busy", 32'(busy), 32'd0);
    check("start+stop done", 32'(done), 32'd0);
    check("start+stop err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    check("start+stop writes", 32'(q_data.size()), 32'd0);

    // Reset while the address phase is stalled drops VALID at once.
    cfg_channel = 4'd1; cfg_store = 2'd0; cfg_freq_start = 32'h55; cfg_step_count = 16'd2;
    aw_delay = 8; clear_log();
    @(negedge clk); sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    @(negedge clk);
    check("pre-reset addr valid", 32'(M_WR_ADDR_VALID), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("mid-reset addr valid", 32'(M_WR_ADDR_VALID), 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset cur_freq", cur_freq, 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1; aw_delay = 0;
    repeat (10) @(negedge clk);
    check("post-reset no resume", 32'(q_data.size()) | 32'(busy), 32'd0);

    for (int r = 0; r < 40; r++) begin
      rv.ch     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      rv.st     = 2'($urandom_range(0, 3));
      rv.fstart = $urandom;
      rv.fstep  = $urandom;
      rv.cnt    = $urandom_range(0, 5);
      rv.dwell  = $urandom_range(0, 3);
      rv.aw     = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
      rv.w      = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
      rv.err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rv.cnt + 1) : 0;
      rv.exp_nwr = 0; rv.exp_addr = '0; rv.exp_last = '0; rv.exp_err = 1'b0;
      sweep(rv, $sformatf("rnd%0d", r), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
